// File: rtl/game_pkg.sv
// Shared types, board constants and helpers for the Generals game core.
package game_pkg;

  localparam int unsigned BoardWidth       = 10;
  localparam int unsigned Log2BoardWidth   = 4;
  localparam int unsigned Log2MaxPlayerCnt = 3;
  localparam int unsigned Log2PieceTypeCnt = 2;
  localparam int unsigned Log2MaxTroop     = 9;
  localparam int unsigned Log2MaxRound     = 12;

  typedef enum logic [Log2MaxPlayerCnt-1:0] {
    PlayerNpc  = 3'd0,
    PlayerRed  = 3'd1,
    PlayerBlue = 3'd2
  } player_e;

  typedef enum logic [Log2PieceTypeCnt-1:0] {
    PieceTerritory = 2'd0,
    PieceMountain  = 2'd1,
    PieceCity      = 2'd2,
    PieceCrown     = 2'd3
  } piece_e;

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StSweep,
    StHalt
  } sched_state_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn timer: tick prescaler feeding a seconds countdown.
module turn_timer #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned TURN_SECONDS  = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,     // synchronous, active low
  input  logic       load_i,
  input  logic       enable_i,
  output logic [4:0] sec_left_o,
  output logic       expire_o
);

  localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SEC - 1);

  logic [TickW-1:0] tick_q, tick_d;
  logic [4:0]       sec_q, sec_d;
  logic             wrap;

  // Next-state for prescaler and countdown; load wins over counting.
  always_comb begin
    tick_d   = tick_q;
    sec_d    = sec_q;
    wrap     = (tick_q == TickLast);
    expire_o = enable_i && wrap && (sec_q == 5'd1);
    if (load_i) begin
      tick_d = '0;
      sec_d  = 5'(TURN_SECONDS);
    end else if (enable_i) begin
      if (wrap) begin
        tick_d = '0;
        if (sec_q != 5'd0) begin
          sec_d = sec_q - 5'd1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tick_q <= '0;
      sec_q  <= '0;
    end else begin
      tick_q <= tick_d;
      sec_q  <= sec_d;
    end
  end

  assign sec_left_o = sec_q;

endmodule

// File: rtl/game_turn_scheduler.sv
// Turn/round sequencer: alternates RED and BLUE, times each turn, and after BLUE's turn
// sweeps the board once applying troop growth through a read-modify-write cell port.
module game_turn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned BORAD_WIDTH         = BoardWidth,
  parameter int unsigned LOG2_BORAD_WIDTH    = Log2BoardWidth,
  parameter int unsigned LOG2_MAX_PLAYER_CNT = Log2MaxPlayerCnt,
  parameter int unsigned LOG2_PIECE_TYPE_CNT = Log2PieceTypeCnt,
  parameter int unsigned LOG2_MAX_TROOP      = Log2MaxTroop,
  parameter int unsigned LOG2_MAX_ROUND      = Log2MaxRound,
  parameter int unsigned TICKS_PER_SEC       = 100_000_000,
  parameter int unsigned TURN_SECONDS        = 10,
  parameter int unsigned GROWTH_PERIOD       = 25
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           turn_done,
  input  logic                           game_over,
  output logic [LOG2_BORAD_WIDTH-1:0]    cell_h,
  output logic [LOG2_BORAD_WIDTH-1:0]    cell_v,
  input  logic [LOG2_MAX_PLAYER_CNT-1:0] cell_owner,
  input  logic [LOG2_PIECE_TYPE_CNT-1:0] cell_type,
  input  logic [LOG2_MAX_TROOP-1:0]      cell_troop,
  output logic                           cell_we,
  output logic [LOG2_MAX_TROOP-1:0]      cell_troop_wr,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_ROUND:0]        round,
  output logic [4:0]                     sec_left,
  output logic                           turn_start,
  output logic                           busy,
  output logic                           halted
);

  localparam int unsigned PlayerW = LOG2_MAX_PLAYER_CNT;
  localparam int unsigned PieceW  = LOG2_PIECE_TYPE_CNT;
  localparam int unsigned RoundW  = LOG2_MAX_ROUND + 1;

  localparam logic [31:0] TroopMax = 32'((64'd1 << LOG2_MAX_TROOP) - 64'd1);
  localparam logic [31:0] RoundMax = 32'((64'd1 << RoundW) - 64'd1);

  localparam logic [LOG2_BORAD_WIDTH-1:0] CoordLast = LOG2_BORAD_WIDTH'(BORAD_WIDTH - 1);

  localparam logic [PlayerW-1:0] PNpc  = PlayerW'(PlayerNpc);
  localparam logic [PlayerW-1:0] PRed  = PlayerW'(PlayerRed);
  localparam logic [PlayerW-1:0] PBlue = PlayerW'(PlayerBlue);

  localparam logic [PieceW-1:0] TTerritory = PieceW'(PieceTerritory);
  localparam logic [PieceW-1:0] TCity      = PieceW'(PieceCity);
  localparam logic [PieceW-1:0] TCrown     = PieceW'(PieceCrown);

  sched_state_e                 state_q, state_d;
  logic [PlayerW-1:0]           player_q, player_d;
  logic [RoundW-1:0]            round_q, round_d;
  logic [LOG2_BORAD_WIDTH-1:0]  h_q, h_d;
  logic [LOG2_BORAD_WIDTH-1:0]  v_q, v_d;
  logic                         turn_start_q, turn_start_d;
  logic                         busy_q, busy_d;
  logic                         halted_q, halted_d;

  logic timer_load;
  logic timer_en;
  logic timer_expire;
  logic owner_grows;
  logic type_grows;
  logic territory_due;

  turn_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .TURN_SECONDS (TURN_SECONDS)
  ) u_turn_timer (
    .clk_i     (clock),
    .rst_ni    (reset),
    .load_i    (timer_load),
    .enable_i  (timer_en),
    .sec_left_o(sec_left),
    .expire_o  (timer_expire)
  );

  // Growth decision for the addressed cell; the write strobe is combinational.
  always_comb begin
    owner_grows   = (cell_owner == PRed) || (cell_owner == PBlue);
    territory_due = ((32'(round_q) % GROWTH_PERIOD) == 32'd0);
    type_grows    = (cell_type == TCrown) || (cell_type == TCity) ||
                    ((cell_type == TTerritory) && territory_due);
    cell_we       = (state_q == StSweep) && owner_grows && type_grows;
    cell_troop_wr = LOG2_MAX_TROOP'(sat_inc(32'(cell_troop), TroopMax));
  end

  // Next-state logic: game_over overrides every other event.
  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    round_d      = round_q;
    h_d          = h_q;
    v_d          = v_q;
    busy_d       = busy_q;
    halted_d     = halted_q;
    turn_start_d = 1'b0;
    timer_load   = 1'b0;
    timer_en     = 1'b0;

    if (game_over) begin
      // Freeze everything in place; an unfinished sweep is simply dropped.
      state_d  = StHalt;
      halted_d = 1'b1;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d      = StTurn;
            player_d     = PRed;
            round_d      = RoundW'(1);
            timer_load   = 1'b1;
            turn_start_d = 1'b1;
          end
        end
        StTurn: begin
          timer_en = 1'b1;
          if (turn_done || timer_expire) begin
            if (player_q == PRed) begin
              player_d     = PBlue;
              timer_load   = 1'b1;
              turn_start_d = 1'b1;
            end else begin
              state_d = StSweep;
              h_d     = '0;
              v_d     = '0;
              busy_d  = 1'b1;
            end
          end
        end
        StSweep: begin
          if (v_q == CoordLast) begin
            v_d = '0;
            if (h_q == CoordLast) begin
              h_d          = '0;
              state_d      = StTurn;
              round_d      = RoundW'(sat_inc(32'(round_q), RoundMax));
              player_d     = PRed;
              timer_load   = 1'b1;
              turn_start_d = 1'b1;
              busy_d       = 1'b0;
            end else begin
              h_d = h_q + 1'b1;
            end
          end else begin
            v_d = v_q + 1'b1;
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      player_q     <= PNpc;
      round_q      <= '0;
      h_q          <= '0;
      v_q          <= '0;
      turn_start_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_q     <= player_d;
      round_q      <= round_d;
      h_q          <= h_d;
      v_q          <= v_d;
      turn_start_q <= turn_start_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
    end
  end

  assign cell_h         = h_q;
  assign cell_v         = v_q;
  assign current_player = player_q;
  assign round          = round_q;
  assign turn_start     = turn_start_q;
  assign busy           = busy_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_game_turn_scheduler.sv
// Scoreboard bench for game_turn_scheduler with a small behavioural board store.
module tb_game_turn_scheduler;
  import game_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        turn_done;
  logic        game_over;
  logic [3:0]  cell_h;
  logic [3:0]  cell_v;
  logic [2:0]  cell_owner;
  logic [1:0]  cell_type;
  logic [8:0]  cell_troop;
  logic        cell_we;
  logic [8:0]  cell_troop_wr;
  logic [2:0]  current_player;
  logic [12:0] round;
  logic [4:0]  sec_left;
  logic        turn_start;
  logic        busy;
  logic        halted;

  game_turn_scheduler #(
    .BORAD_WIDTH        (10),
    .LOG2_BORAD_WIDTH   (4),
    .LOG2_MAX_PLAYER_CNT(3),
    .LOG2_PIECE_TYPE_CNT(2),
    .LOG2_MAX_TROOP     (9),
    .LOG2_MAX_ROUND     (12),
    .TICKS_PER_SEC      (4),
    .TURN_SECONDS       (3),
    .GROWTH_PERIOD      (2)
  ) dut (
    .clock         (clk),
    .reset         (rst_n),
    .start         (start),
    .turn_done     (turn_done),
    .game_over     (game_over),
    .cell_h        (cell_h),
    .cell_v        (cell_v),
    .cell_owner    (cell_owner),
    .cell_type     (cell_type),
    .cell_troop    (cell_troop),
    .cell_we       (cell_we),
    .cell_troop_wr (cell_troop_wr),
    .current_player(current_player),
    .round         (round),
    .sec_left      (sec_left),
    .turn_start    (turn_start),
    .busy          (busy),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Board store: owner/type set by stimulus, troop written by DUT or preload port.
  logic [2:0] b_owner[100];
  logic [1:0] b_type[100];
  logic [8:0] b_troop[100];
  int         wr_cnt[100];
  int         cell_idx;
  logic       pre_we;
  int         pre_idx;
  logic [8:0] pre_val;
  logic       clr_cnt;

  always_comb begin
    cell_idx   = int'(cell_h) * 10 + int'(cell_v);
    cell_owner = 3'd0;
    cell_type  = 2'd0;
    cell_troop = 9'd0;
    if (cell_idx < 100) begin
      cell_owner = b_owner[cell_idx];
      cell_type  = b_type[cell_idx];
      cell_troop = b_troop[cell_idx];
    end
  end

  always @(posedge clk) begin
    if (cell_we && cell_idx < 100) begin
      b_troop[cell_idx] <= cell_troop_wr;
      wr_cnt[cell_idx]  <= wr_cnt[cell_idx] + 1;
    end
    if (pre_we) b_troop[pre_idx] <= pre_val;
    if (clr_cnt) for (int i = 0; i < 100; i++) wr_cnt[i] <= 0;
  end

  // Scoreboard of expected turn_start events.
  typedef struct {
    int player;
    int rnd;
    int sec;
    int at;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_ts(input int p, input int r, input int s, input int at);
    exp_t e;
    e.player = p;
    e.rnd    = r;
    e.sec    = s;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (turn_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_turn_start", 32'(turn_start), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ts_cycle", 32'(cyc), 32'(e.at));
        chk("ts_player", 32'(current_player), 32'(e.player));
        chk("ts_round", 32'(round), 32'(e.rnd));
        chk("ts_sec_left", 32'(sec_left), 32'(e.sec));
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic set_cell(input int i, input logic [2:0] o, input logic [1:0] t,
                          input logic [8:0] tr);
    b_owner[i] = o;
    b_type[i]  = t;
    pre_idx    = i;
    pre_val    = tr;
    pre_we     = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_player"}, 32'(current_player), 32'd0);
    chk({tag, "_round"}, 32'(round), 32'd0);
    chk({tag, "_sec_left"}, 32'(sec_left), 32'd0);
    chk({tag, "_turn_start"}, 32'(turn_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_cell_we"}, 32'(cell_we), 32'd0);
    chk({tag, "_cell_h"}, 32'(cell_h), 32'd0);
    chk({tag, "_cell_v"}, 32'(cell_v), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [2:0] Npc  = 3'd0;
  localparam logic [2:0] Red  = 3'd1;
  localparam logic [2:0] Blue = 3'd2;
  localparam logic [1:0] Terr = 2'd0;
  localparam logic [1:0] Mtn  = 2'd1;
  localparam logic [1:0] City = 2'd2;
  localparam logic [1:0] Crwn = 2'd3;

  initial begin
    int k, m, r, b, s, q, sum_wr;
    rst_n     = 1'b0;
    start     = 1'b0;
    turn_done = 1'b0;
    game_over = 1'b0;
    pre_we    = 1'b0;
    pre_idx   = 0;
    pre_val   = '0;
    clr_cnt   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      b_owner[i] = Npc;
      b_type[i]  = Terr;
    end
    @(negedge clk);
    for (int i = 0; i < 100; i++) set_cell(i, Npc, Terr, 9'd0);
    set_cell(3, Red, Crwn, 9'h057);
    set_cell(12, Npc, City, 9'h020);
    set_cell(20, Red, Terr, 9'h005);
    set_cell(50, Blue, City, 9'h1FF);
    set_cell(60, Red, Mtn, 9'h010);
    set_cell(37, Red, Crwn, 9'h007);
    set_cell(38, Blue, Crwn, 9'h009);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk_reset_vals("reset");

    // Start and let RED time out.
    rst_n = 1'b1;
    @(negedge clk);
    k = cyc;
    start = 1'b1;
    push_ts(1, 1, 3, k + 1);
    push_ts(2, 1, 3, k + 13);
    @(negedge clk);
    start = 1'b0;
    wait_cyc(k + 4);
    chk("sec_before_wrap", 32'(sec_left), 32'd3);
    wait_cyc(k + 5);
    chk("sec_after_wrap1", 32'(sec_left), 32'd2);
    wait_cyc(k + 9);
    chk("sec_after_wrap2", 32'(sec_left), 32'd1);
    wait_cyc(k + 12);
    chk("red_still_active", 32'(current_player), 32'd1);

    // BLUE commits; first sweep (round 1, territory not due).
    wait_cyc(k + 13);
    m = cyc;
    turn_done = 1'b1;
    push_ts(1, 2, 3, m + 101);
    @(negedge clk);
    turn_done = 1'b0;
    chk("sweep_busy_first", 32'(busy), 32'd1);
    chk("sweep_h0", 32'(cell_h), 32'd0);
    chk("sweep_v0", 32'(cell_v), 32'd0);
    wait_cyc(m + 11);
    chk("sweep_h1", 32'(cell_h), 32'd1);
    chk("sweep_v_wrap", 32'(cell_v), 32'd0);
    wait_cyc(m + 100);
    chk("sweep_busy_last", 32'(busy), 32'd1);
    wait_cyc(m + 101);
    chk("sweep_busy_done", 32'(busy), 32'd0);
    chk("r1_crown", 32'(b_troop[3]), 32'h058);
    chk("r1_npc_city", 32'(b_troop[12]), 32'h020);
    chk("r1_territory", 32'(b_troop[20]), 32'h005);
    chk("r1_sat_city", 32'(b_troop[50]), 32'h1FF);
    chk("r1_mountain", 32'(b_troop[60]), 32'h010);
    chk("r1_c37", 32'(b_troop[37]), 32'h008);
    chk("r1_c38", 32'(b_troop[38]), 32'h00A);

    // turn_done lands on RED's timeout cycle: one switch only.
    r = m + 101;
    wait_cyc(r + 11);
    turn_done = 1'b1;
    b = r + 12;
    push_ts(2, 2, 3, b);
    push_ts(1, 3, 3, b + 112);
    @(negedge clk);
    turn_done = 1'b0;
    wait_cyc(r + 13);
    chk("coincide_player", 32'(current_player), 32'd2);
    chk("coincide_sec", 32'(sec_left), 32'd3);

    // BLUE times out; second sweep (round 2, territory due).
    wait_cyc(b + 112);
    chk("r2_round_next", 32'(round), 32'd3);
    chk("r2_territory", 32'(b_troop[20]), 32'h006);
    chk("r2_sat_city", 32'(b_troop[50]), 32'h1FF);
    chk("r2_crown", 32'(b_troop[3]), 32'h059);
    chk("r2_npc_city", 32'(b_troop[12]), 32'h020);
    chk("r2_mountain", 32'(b_troop[60]), 32'h010);
    chk("r2_c37", 32'(b_troop[37]), 32'h009);
    chk("r2_c38", 32'(b_troop[38]), 32'h00B);

    // Round 3: both players commit, game_over hits at sweep cell 37.
    s = cyc;
    clr_cnt   = 1'b1;
    turn_done = 1'b1;
    push_ts(2, 3, 3, s + 1);
    @(negedge clk);
    clr_cnt = 1'b0;
    @(negedge clk);
    turn_done = 1'b0;
    wait_cyc(s + 39);
    chk("abort_at_h", 32'(cell_h), 32'd3);
    chk("abort_at_v", 32'(cell_v), 32'd7);
    chk("abort_we_37", 32'(cell_we), 32'd1);
    game_over = 1'b1;
    wait_cyc(s + 40);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_cell_we", 32'(cell_we), 32'd0);
    chk("halt_round", 32'(round), 32'd3);
    chk("halt_player", 32'(current_player), 32'd2);
    chk("halt_c37", 32'(b_troop[37]), 32'h00A);
    chk("halt_c38", 32'(b_troop[38]), 32'h00B);
    chk("halt_c3", 32'(b_troop[3]), 32'h05A);
    sum_wr = 0;
    for (int i = 38; i < 100; i++) sum_wr += wr_cnt[i];
    chk("halt_unwritten_38_99", 32'(sum_wr), 32'd0);
    chk("halt_c37_once", 32'(wr_cnt[37]), 32'd1);
    @(negedge clk);
    game_over = 1'b0;
    turn_done = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    turn_done = 1'b0;
    start     = 1'b0;
    wait_cyc(s + 46);
    chk("halt_hold_halted", 32'(halted), 32'd1);
    chk("halt_hold_player", 32'(current_player), 32'd2);
    chk("halt_hold_round", 32'(round), 32'd3);
    chk("halt_hold_sec", 32'(sec_left), 32'd3);
    chk("halt_hold_h", 32'(cell_h), 32'd3);
    chk("halt_hold_v", 32'(cell_v), 32'd7);

    // Reset out of HALT, run to a sweep, then reset mid-sweep.
    rst_n = 1'b0;
    @(negedge clk);
    set_cell(0, Red, Crwn, 9'h001);
    chk_reset_vals("halt_reset");
    q = cyc;
    rst_n = 1'b1;
    start = 1'b1;
    push_ts(1, 1, 3, q + 1);
    push_ts(2, 1, 3, q + 2);
    @(negedge clk);
    start     = 1'b0;
    turn_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    turn_done = 1'b0;
    chk("sweep2_we_cell0", 32'(cell_we), 32'd1);
    wait_cyc(q + 8);
    chk("sweep2_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    wait_cyc(q + 9);
    chk_reset_vals("mid_sweep_reset");
    rst_n = 1'b1;
    wait_cyc(q + 12);
    chk("idle_after_reset", 32'(current_player), 32'd0);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("missing_turn_start", 32'(cyc), 32'(e.at));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
